// File: rtl/period_detector.sv
// Period detector: Schmitt-trigger crossing detector on the filtered sample stream.
// Reports the sample count between successive rising crossings and tracks signal presence.
module period_detector #(
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned COUNT_BITS = 16,
    parameter int unsigned MIN_PERIOD = 8,
    parameter int unsigned TIMEOUT    = 4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [DATA_BITS-1:0]  din,
    input  logic [DATA_BITS-1:0]  midpoint,
    input  logic [DATA_BITS-1:0]  hyst,
    output logic [COUNT_BITS-1:0] period,
    output logic                  period_valid,
    output logic                  signal_present
);

    typedef enum logic [1:0] {StWaitLow, StArmed, StHigh, StLow} state_e;

    localparam logic [COUNT_BITS-1:0] MinPeriodC = COUNT_BITS'(MIN_PERIOD);
    localparam logic [COUNT_BITS-1:0] TimeoutC   = COUNT_BITS'(TIMEOUT);

    state_e                state_q, state_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [COUNT_BITS-1:0] period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  present_q, present_d;

    logic [DATA_BITS:0]    sum_wide, diff_wide;
    logic [DATA_BITS-1:0]  hi_thr, lo_thr;
    logic [COUNT_BITS-1:0] cnt_inc;
    logic                  is_high, is_low;

    // One extra bit catches overflow/underflow of the band edges before clamping.
    assign sum_wide  = {1'b0, midpoint} + {1'b0, hyst};
    assign diff_wide = {1'b0, midpoint} - {1'b0, hyst};

    always_comb begin
        hi_thr = sum_wide[DATA_BITS-1:0];
        lo_thr = diff_wide[DATA_BITS-1:0];
        if (sum_wide[DATA_BITS]) hi_thr = '1;
        if (diff_wide[DATA_BITS]) lo_thr = '0;
    end

    assign is_high = (din >= hi_thr);
    assign is_low  = (din <= lo_thr);
    assign cnt_inc = cnt_q + COUNT_BITS'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        present_d = present_q;
        if (sample_en) begin
            unique case (state_q)
                StWaitLow: begin
                    cnt_d = '0;
                    if (is_low) state_d = StArmed;
                end
                StArmed: begin
                    if (is_high) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end
                end
                StHigh, StLow: begin
                    // Timeout wins over any crossing seen on the same sample.
                    if (cnt_inc >= TimeoutC) begin
                        state_d   = StWaitLow;
                        cnt_d     = '0;
                        present_d = 1'b0;
                    end else if (state_q == StHigh) begin
                        cnt_d = cnt_inc;
                        if (is_low) state_d = StLow;
                    end else if (is_high) begin
                        state_d = StHigh;
                        if (cnt_inc >= MinPeriodC) begin
                            period_d  = cnt_inc;
                            valid_d   = 1'b1;
                            present_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            // Too-short crossing: keep counting from the last accepted edge.
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StWaitLow;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitLow;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            present_q <= present_d;
        end
    end

    assign period         = period_q;
    assign period_valid   = valid_q;
    assign signal_present = present_q;

endmodule

// File: tb/tb_period_detector.sv
// Self-checking bench for period_detector: expected periods are queued when the
// crossing sample is driven and compared when period_valid pulses.
module tb_period_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] din = 12'd2048;
    logic [11:0] midpoint = 12'd2048;
    logic [11:0] hyst = 12'd64;
    logic [15:0] period;
    logic        period_valid;
    logic        signal_present;

    int n_checks = 0;
    int n_errors = 0;
    int gap = 3;
    int unsigned exp_q[$];

    period_detector #(
        .DATA_BITS (12),
        .COUNT_BITS(16),
        .MIN_PERIOD(8),
        .TIMEOUT   (4000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .din           (din),
        .midpoint      (midpoint),
        .hyst          (hyst),
        .period        (period),
        .period_valid  (period_valid),
        .signal_present(signal_present)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic put(input logic [11:0] d);
        din       = d;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // n periods of half low samples then half high samples; the first high sample
    // of period p reports 2*half once p >= skip. dip >= 0 puts a low sample there.
    task automatic period_wave(input logic [11:0] lv, input logic [11:0] hv, input int half,
                               input int n, input int skip, input int dip);
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < half; j++) put(lv);
            for (int j = 0; j < half; j++) begin
                if (j == 0 && p >= skip) exp_q.push_back(2 * half);
                put((j == dip) ? lv : hv);
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        check_val(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && period_valid) begin
            if (exp_q.size() == 0) check_val("unexpected_valid", period_valid, 0);
            else check_val("period", period, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_period", period, 0);
        check_val("rst_valid", period_valid, 0);
        check_val("rst_present", signal_present, 0);
        rst = 1'b0;
        @(negedge clk);

        // In-band oscillation from WAIT_LOW never arms.
        for (int i = 0; i < 500; i++) put((i % 2) ? 12'd2100 : 12'd2000);
        drain("band_drain");
        check_val("band_present", signal_present, 0);
        check_val("band_period", period, 0);

        // Square wave, first period only sets the reference edge.
        period_wave(12'd1000, 12'd3000, 50, 1, 1, -1);
        drain("sq_first_drain");
        check_val("sq_present_before", signal_present, 0);
        period_wave(12'd1000, 12'd3000, 50, 4, 0, -1);
        drain("sq_drain");
        check_val("sq_present", signal_present, 1);
        check_val("sq_period", period, 100);

        // Early dip right after an accepted edge is rejected as a glitch.
        period_wave(12'd1000, 12'd3000, 50, 3, 0, 3);
        drain("glitch_drain");
        check_val("glitch_period", period, 100);

        // Held high: timeout on the 4000th sample after the last edge, back-to-back samples.
        gap = 0;
        for (int i = 0; i < 3950; i++) put(12'd3000);
        check_val("pre_timeout_present", signal_present, 1);
        put(12'd3000);
        check_val("timeout_present", signal_present, 0);
        check_val("timeout_period", period, 100);
        gap = 3;
        period_wave(12'd1000, 12'd3000, 50, 1, 1, -1);
        drain("resume_first_drain");
        check_val("resume_present_before", signal_present, 0);
        period_wave(12'd1000, 12'd3000, 50, 2, 0, -1);
        drain("resume_drain");
        check_val("resume_present", signal_present, 1);

        // Clamped thresholds at both ends of the range.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        midpoint = 12'd4090;
        period_wave(12'd0, 12'd4095, 20, 3, 1, -1);
        drain("clamp_hi_drain");
        check_val("clamp_hi_period", period, 40);
        midpoint = 12'd10;
        period_wave(12'd0, 12'd4095, 20, 3, 0, -1);
        drain("clamp_lo_drain");
        check_val("clamp_lo_period", period, 40);
        check_val("clamp_present", signal_present, 1);

        // Asynchronous reset in the middle of a low phase.
        midpoint = 12'd2048;
        for (int i = 0; i < 10; i++) put(12'd1000);
        #3 rst = 1'b1;
        #1;
        check_val("async_rst_period", period, 0);
        check_val("async_rst_present", signal_present, 0);
        check_val("async_rst_valid", period_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        period_wave(12'd1000, 12'd3000, 30, 1, 1, -1);
        drain("post_rst_first_drain");
        check_val("post_rst_present_before", signal_present, 0);
        period_wave(12'd1000, 12'd3000, 30, 2, 0, -1);
        drain("post_rst_drain");
        check_val("post_rst_period", period, 60);
        check_val("post_rst_present", signal_present, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
